cmos_to_axis: RTL and testbench

Converts the sampled CMOS sensor stream (vsync/href/pixel data, all on `pixel_clk`) into an AXI4-Stream video master with start-of-frame (`tuser`) and end-of-line (`tlast`) markers. A small FIFO absorbs downstream backpressure. The block also measures the frame geometry. It sits directly downstream of the CMOS sampling stage and feeds the image-processing/VDMA path.

---
 rtl/cmos_pkg.sv | 24 ++
 rtl/pix_fifo.sv | 70 +++++++
 rtl/cmos_to_axis.sv | 234 +++++++++++++++++++++++
 tb/tb_cmos_to_axis.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmos_pkg
//  Description : Shared types and constants for the CMOS-to-AXI4-Stream
//                converter: capture state encoding and FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmos_pkg;

    // Capture state machine encoding
    typedef enum logic [1:0] {
        SYNC     = 2'd0,   // waiting for a vsync high to align to a frame
        WAIT_SOF = 2'd1,   // in vertical blanking, waiting for vsync low
        ACTIVE   = 2'd2,   // capturing pixels of the current frame
        DROP     = 2'd3    // frame corrupted by overrun, discard until vsync
    } state_t;

    // FIFO entry is {tuser, tlast, data}; the sideband bit positions are
    // given as offsets above the data field (add DATA_WIDTH to get the bit).
    localparam int TLAST_BIT = 0;
    localparam int TUSER_BIT = 1;

endpackage : cmos_pkg
`default_nettype wire

// File: rtl/pix_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pix_fifo
//  Description : Synchronous show-ahead FIFO. The head entry is presented on
//                o_rd_data whenever the FIFO is not empty (zero when empty).
//                A write into a full FIFO is accepted when a read happens in
//                the same cycle. DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign w_rd      = i_rd_en && !o_empty;
    // A simultaneous read frees the slot, so full does not block that write
    assign w_wr      = i_wr_en && (!o_full || w_rd);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array write; contents need no reset as reads are gated by empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of 2)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : pix_fifo
`default_nettype wire

// File: rtl/cmos_to_axis.sv
`default_nettype none
// ============================================================================
//  Module      : cmos_to_axis
//  Description : Converts a sampled CMOS vsync/href/pixel stream into an
//                AXI4-Stream video master with tuser (start of frame) and
//                tlast (end of line). A show-ahead FIFO absorbs downstream
//                backpressure; overruns drop the rest of the frame and set a
//                sticky flag. Frame width/height are measured per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmos_to_axis
    import cmos_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  pixel_clk,
    input  logic                  rst,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  frame_width,
    output logic [CNT_WIDTH-1:0]  frame_height,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int                   c_ENTRY_W   = DATA_WIDTH + 2;
    localparam int                   c_TLAST_POS = DATA_WIDTH + TLAST_BIT;
    localparam int                   c_TUSER_POS = DATA_WIDTH + TUSER_BIT;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = '1;

    // Capture state
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_active;
    logic                  w_frame_end;

    // One-entry pixel stage between the sensor and the FIFO
    logic                  r_stage_valid;
    logic                  r_stage_tuser;
    logic [DATA_WIDTH-1:0] r_stage_data;
    logic                  w_load;
    logic                  w_push_tlast;

    // Frame bookkeeping
    logic                  r_sof_pending;
    logic                  r_first_line;
    logic                  r_href_d;
    logic                  w_href_fall;
    logic [CNT_WIDTH-1:0]  r_pix_cnt;
    logic [CNT_WIDTH-1:0]  r_line_cnt;
    logic [CNT_WIDTH-1:0]  w_pix_next;
    logic [CNT_WIDTH-1:0]  w_line_next;
    logic [CNT_WIDTH-1:0]  r_frame_width;
    logic [CNT_WIDTH-1:0]  r_frame_height;
    logic                  r_frame_done;
    logic                  r_overflow;

    // FIFO interface
    logic                  w_pop;
    logic                  w_push;
    logic                  w_overrun;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_ENTRY_W-1:0]  w_push_entry;
    logic [c_ENTRY_W-1:0]  w_fifo_rd_data;

    assign w_active    = (r_state == ACTIVE);
    // r_href_d is only ever set while capturing, so this is an in-frame fall
    assign w_href_fall = w_active && r_href_d && !href;

    assign w_pop       = !w_fifo_empty && m_axis_tready;
    // The stage always attempts a write; it only fails on a full FIFO that
    // is not also being drained this cycle
    assign w_overrun   = r_stage_valid && w_fifo_full && !w_pop;
    assign w_push      = r_stage_valid && !w_overrun;
    assign w_load      = w_active && href && !w_overrun;

    // The staged pixel ends its line unless another pixel of the same line
    // is being captured on this very edge
    assign w_push_tlast = !(w_active && href);
    assign w_push_entry = {r_stage_tuser, w_push_tlast, r_stage_data};

    // Next-state logic; overrun wins over a coincident frame end so a
    // corrupted frame never reports its geometry
    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        case (r_state)
            SYNC: begin
                if (vsync) w_state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!vsync) w_state_next = ACTIVE;
            end
            ACTIVE: begin
                if (w_overrun) begin
                    w_state_next = DROP;
                end else if (vsync) begin
                    w_state_next = WAIT_SOF;
                    w_frame_end  = 1'b1;
                end
            end
            DROP: begin
                if (vsync) w_state_next = WAIT_SOF;
            end
            default: w_state_next = SYNC;
        endcase
    end

    // State register
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stage register: capture a pixel, hand it to the FIFO on the next edge
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_stage_valid <= 1'b0;
            r_stage_tuser <= 1'b0;
            r_stage_data  <= '0;
        end else begin
            r_stage_valid <= w_load;
            if (w_load) begin
                r_stage_tuser <= r_sof_pending;
                r_stage_data  <= data_in;
            end
        end
    end

    // Frame-position flags: start-of-frame marker, first-line window, href history
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_sof_pending <= 1'b1;
            r_first_line  <= 1'b1;
            r_href_d      <= 1'b0;
        end else begin
            r_href_d <= w_active && href;
            if (!w_active) begin
                r_sof_pending <= 1'b1;
                r_first_line  <= 1'b1;
            end else begin
                if (href) r_sof_pending <= 1'b0;
                if (w_href_fall) r_first_line <= 1'b0;
            end
        end
    end

    // Saturating next values for the width and height counters
    always_comb begin
        w_pix_next  = r_pix_cnt;
        w_line_next = r_line_cnt;
        if (w_active && href && r_first_line && (r_pix_cnt != c_CNT_MAX)) begin
            w_pix_next = r_pix_cnt + 1'b1;
        end
        if (w_href_fall && (r_line_cnt != c_CNT_MAX)) begin
            w_line_next = r_line_cnt + 1'b1;
        end
    end

    // Counters run only while staying in ACTIVE and clear on any exit
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (w_active && (w_state_next == ACTIVE)) begin
            r_pix_cnt  <= w_pix_next;
            r_line_cnt <= w_line_next;
        end else begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end
    end

    // Publish geometry at a clean frame end, including a fall on that edge
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_frame_width  <= '0;
            r_frame_height <= '0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_width  <= w_pix_next;
                r_frame_height <= w_line_next;
            end
        end
    end

    // Sticky overrun flag
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_overrun) begin
            r_overflow <= 1'b1;
        end
    end

    pix_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk       (pixel_clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign m_axis_tvalid = !w_fifo_empty;
    assign m_axis_tdata  = w_fifo_rd_data[DATA_WIDTH-1:0];
    assign m_axis_tlast  = w_fifo_rd_data[c_TLAST_POS];
    assign m_axis_tuser  = w_fifo_rd_data[c_TUSER_POS];
    assign frame_width   = r_frame_width;
    assign frame_height  = r_frame_height;
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;

endmodule : cmos_to_axis
`default_nettype wire

// File: tb/tb_cmos_to_axis.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmos_to_axis
//  Description : Directed self-checking bench for cmos_to_axis. Each task
//                drives one scenario and checks results inline against
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmos_to_axis;

    logic        pixel_clk;
    logic        rst;
    logic        vsync;
    logic        href;
    logic [7:0]  data_in;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic [11:0] frame_width;
    logic [11:0] frame_height;
    logic        frame_done;
    logic        overflow;

    int          checks;
    int          passed;
    int          fd_cnt;
    logic [9:0]  beats [$];   // {tuser, tlast, data}

    cmos_to_axis #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .CNT_WIDTH  (12)
    ) dut (
        .pixel_clk     (pixel_clk),
        .rst           (rst),
        .vsync         (vsync),
        .href          (href),
        .data_in       (data_in),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .frame_width   (frame_width),
        .frame_height  (frame_height),
        .frame_done    (frame_done),
        .overflow      (overflow)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Collect handshaken beats and frame_done pulses midway between edges
    always @(negedge pixel_clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready)
                beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            if (frame_done)
                fd_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pixel_clk);
            #1;
        end
    endtask

    task automatic drive_line(input logic [7:0] first, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            href    = 1'b1;
            data_in = first + 8'(i);
            idle(1);
        end
        href    = 1'b0;
        data_in = 8'h00;
        idle(gap);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        idle(3);
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int k = 0; k < budget && beats.size() < n; k++) idle(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b0; href = 1'b0; data_in = 8'h00; m_axis_tready = 1'b0;
        idle(3);
        checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%0h exp=0", m_axis_tvalid); else passed++;
        checks++; if (m_axis_tdata !== 8'h00) $display("FAIL reset_tdata got=%0h exp=0", m_axis_tdata); else passed++;
        checks++; if (m_axis_tuser !== 1'b0) $display("FAIL reset_tuser got=%0h exp=0", m_axis_tuser); else passed++;
        checks++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast got=%0h exp=0", m_axis_tlast); else passed++;
        checks++; if (frame_width !== 12'd0) $display("FAIL reset_width got=%0d exp=0", frame_width); else passed++;
        checks++; if (frame_height !== 12'd0) $display("FAIL reset_height got=%0d exp=0", frame_height); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_done got=%0h exp=0", frame_done); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%0h exp=0", overflow); else passed++;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        logic [9:0] exp;
        logic [9:0] got;
        m_axis_tready = 1'b1;
        beats.delete(); fd_cnt = 0;
        vsync_pulse();
        drive_line(8'h01, 4, 3);
        drive_line(8'h05, 4, 3);
        drive_line(8'h09, 4, 3);
        vsync = 1'b1;
        idle(6);
        checks++; if (beats.size() != 12) $display("FAIL basic_count got=%0d exp=12", beats.size()); else passed++;
        for (int i = 0; i < 12; i++) begin
            exp = {(i == 0), (i % 4 == 3), 8'(i + 1)};
            got = (i < beats.size()) ? beats[i] : 10'bx;
            checks++; if (got !== exp) $display("FAIL basic_beat%0d got=%0h exp=%0h", i, got, exp); else passed++;
        end
        checks++; if (frame_width !== 12'd4) $display("FAIL basic_width got=%0d exp=4", frame_width); else passed++;
        checks++; if (frame_height !== 12'd3) $display("FAIL basic_height got=%0d exp=3", frame_height); else passed++;
        checks++; if (fd_cnt != 1) $display("FAIL basic_done_pulses got=%0d exp=1", fd_cnt); else passed++;
    endtask

    task automatic test_latency();
        m_axis_tready = 1'b1;
        vsync_pulse();
        href = 1'b1; data_in = 8'hA5;
        idle(1);   // edge k: pixel sampled into the stage
        checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL latency_k got=%0h exp=0", m_axis_tvalid); else passed++;
        href = 1'b0; data_in = 8'h00;
        idle(1);   // edge k+1: pixel pushed into the FIFO
        checks++; if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== {3'b111, 8'hA5})
            $display("FAIL latency_k1 got=%0h exp=%0h", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {3'b111, 8'hA5});
        else passed++;
        idle(3);
        vsync = 1'b1;
        idle(4);
    endtask

    task automatic test_midframe();
        logic [9:0] exp [4];
        logic [9:0] got;
        exp[0] = 10'h260; exp[1] = 10'h161; exp[2] = 10'h070; exp[3] = 10'h171;
        m_axis_tready = 1'b1;
        rst = 1'b1; vsync = 1'b0; href = 1'b1; data_in = 8'h40;
        idle(2);
        rst = 1'b0;
        beats.delete(); fd_cnt = 0;
        idle(2);
        href = 1'b0;
        idle(2);
        drive_line(8'h48, 4, 2);
        checks++; if (frame_width !== 12'd0) $display("FAIL mid_width_cleared got=%0d exp=0", frame_width); else passed++;
        vsync = 1'b1;
        idle(3);
        checks++; if (beats.size() != 0) $display("FAIL mid_no_beats got=%0d exp=0", beats.size()); else passed++;
        vsync = 1'b0;
        idle(3);
        drive_line(8'h60, 2, 2);
        drive_line(8'h70, 2, 2);
        vsync = 1'b1;
        idle(5);
        checks++; if (beats.size() != 4) $display("FAIL mid_count got=%0d exp=4", beats.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            got = (i < beats.size()) ? beats[i] : 10'bx;
            checks++; if (got !== exp[i]) $display("FAIL mid_beat%0d got=%0h exp=%0h", i, got, exp[i]); else passed++;
        end
        checks++; if ({frame_width, frame_height} !== {12'd2, 12'd2})
            $display("FAIL mid_geometry got=%0d/%0d exp=2/2", frame_width, frame_height); else passed++;
        checks++; if (fd_cnt != 1) $display("FAIL mid_done_pulses got=%0d exp=1", fd_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        logic [9:0] exp;
        logic [9:0] got;
        m_axis_tready = 1'b0;
        beats.delete();
        vsync_pulse();
        drive_line(8'h10, 10, 2);
        idle(2);
        checks++; if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== {2'b11, 8'h10})
            $display("FAIL bp_head got=%0h exp=%0h", {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {2'b11, 8'h10}); else passed++;
        idle(3);
        checks++; if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== {3'b110, 8'h10})
            $display("FAIL bp_hold got=%0h exp=%0h", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {3'b110, 8'h10}); else passed++;
        m_axis_tready = 1'b1;
        wait_beats(10, 40);
        vsync = 1'b1;
        idle(5);
        checks++; if (beats.size() != 10) $display("FAIL bp_count got=%0d exp=10", beats.size()); else passed++;
        for (int i = 0; i < 10; i++) begin
            exp = {(i == 0), (i == 9), 8'h10 + 8'(i)};
            got = (i < beats.size()) ? beats[i] : 10'bx;
            checks++; if (got !== exp) $display("FAIL bp_beat%0d got=%0h exp=%0h", i, got, exp); else passed++;
        end
        checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow got=%0h exp=0", overflow); else passed++;
        checks++; if ({frame_width, frame_height} !== {12'd10, 12'd1})
            $display("FAIL bp_geometry got=%0d/%0d exp=10/1", frame_width, frame_height); else passed++;
    endtask

    task automatic test_overrun();
        logic [9:0] exp;
        logic [9:0] got;
        m_axis_tready = 1'b0;
        beats.delete(); fd_cnt = 0;
        vsync_pulse();
        for (int i = 0; i < 40; i++) begin
            href = 1'b1; data_in = 8'h80 + 8'(i);
            idle(1);   // after edge i: pixel i-1 has just attempted its push
            if (i == 16) begin
                checks++; if (overflow !== 1'b0) $display("FAIL ovr_16th_push got=%0h exp=0", overflow); else passed++;
            end
            if (i == 17) begin
                checks++; if (overflow !== 1'b1) $display("FAIL ovr_17th_push got=%0h exp=1", overflow); else passed++;
            end
        end
        href = 1'b0; data_in = 8'h00;
        vsync = 1'b1;
        idle(4);
        checks++; if (fd_cnt != 0) $display("FAIL ovr_no_done got=%0d exp=0", fd_cnt); else passed++;
        checks++; if (frame_width !== 12'd10) $display("FAIL ovr_width_kept got=%0d exp=10", frame_width); else passed++;
        m_axis_tready = 1'b1;
        wait_beats(16, 40);
        idle(3);
        checks++; if (beats.size() != 16) $display("FAIL ovr_drain_count got=%0d exp=16", beats.size()); else passed++;
        for (int i = 0; i < 16; i++) begin
            exp = {(i == 0), 1'b0, 8'h80 + 8'(i)};
            got = (i < beats.size()) ? beats[i] : 10'bx;
            checks++; if (got !== exp) $display("FAIL ovr_beat%0d got=%0h exp=%0h", i, got, exp); else passed++;
        end
        beats.delete(); fd_cnt = 0;
        vsync_pulse();
        drive_line(8'h30, 3, 2);
        drive_line(8'h33, 3, 2);
        vsync = 1'b1;
        idle(5);
        checks++; if (beats.size() != 6) $display("FAIL ovr_next_count got=%0d exp=6", beats.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            exp = {(i == 0), (i == 2 || i == 5), 8'h30 + 8'(i)};
            got = (i < beats.size()) ? beats[i] : 10'bx;
            checks++; if (got !== exp) $display("FAIL ovr_next_beat%0d got=%0h exp=%0h", i, got, exp); else passed++;
        end
        checks++; if ({frame_width, frame_height} !== {12'd3, 12'd2})
            $display("FAIL ovr_next_geometry got=%0d/%0d exp=3/2", frame_width, frame_height); else passed++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovr_sticky got=%0h exp=1", overflow); else passed++;
        checks++; if (fd_cnt != 1) $display("FAIL ovr_next_done got=%0d exp=1", fd_cnt); else passed++;
    endtask

    task automatic test_boundary();
        logic [9:0] exp;
        logic [9:0] got;
        m_axis_tready = 1'b1;
        beats.delete(); fd_cnt = 0;
        vsync_pulse();
        drive_line(8'hC1, 1, 2);
        drive_line(8'hC2, 1, 2);
        drive_line(8'hC3, 1, 2);
        vsync = 1'b1;
        idle(5);
        checks++; if (beats.size() != 3) $display("FAIL b1_count got=%0d exp=3", beats.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            exp = {(i == 0), 1'b1, 8'hC1 + 8'(i)};
            got = (i < beats.size()) ? beats[i] : 10'bx;
            checks++; if (got !== exp) $display("FAIL b1_beat%0d got=%0h exp=%0h", i, got, exp); else passed++;
        end
        checks++; if ({frame_width, frame_height} !== {12'd1, 12'd3})
            $display("FAIL b1_geometry got=%0d/%0d exp=1/3", frame_width, frame_height); else passed++;
        // vsync rises on the same edge that href falls
        beats.delete(); fd_cnt = 0;
        vsync_pulse();
        for (int i = 0; i < 3; i++) begin
            href = 1'b1; data_in = 8'hD0 + 8'(i);
            idle(1);
        end
        href = 1'b0; data_in = 8'h00; vsync = 1'b1;
        idle(5);
        checks++; if (beats.size() != 3) $display("FAIL bv_count got=%0d exp=3", beats.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            exp = {(i == 0), (i == 2), 8'hD0 + 8'(i)};
            got = (i < beats.size()) ? beats[i] : 10'bx;
            checks++; if (got !== exp) $display("FAIL bv_beat%0d got=%0h exp=%0h", i, got, exp); else passed++;
        end
        checks++; if ({frame_width, frame_height} !== {12'd3, 12'd1})
            $display("FAIL bv_geometry got=%0d/%0d exp=3/1", frame_width, frame_height); else passed++;
        checks++; if (fd_cnt != 1) $display("FAIL bv_done got=%0d exp=1", fd_cnt); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        fd_cnt = 0;
        test_reset();
        test_basic();
        test_latency();
        test_midframe();
        test_backpressure();
        test_overrun();
        test_boundary();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_cmos_to_axis
`default_nettype wire
